// File: rtl/mux8x1_rr_scheduler_if.sv
// Bus between the requesters/consumer and the round-robin lane scheduler.
// The lock signal exists only when MUX_RR_LOCK_EN is defined.
interface mux8x1_rr_scheduler_if #(
  parameter int DATA_W = 1
);
  logic [7:0]          req;
  logic [8*DATA_W-1:0] in;
  logic                out_ready;
`ifdef MUX_RR_LOCK_EN
  logic                lock;
`endif
  logic [2:0]          sel;
  logic [7:0]          grant;
  logic                out_valid;
  logic [DATA_W-1:0]   out;
  logic                busy;

`ifdef MUX_RR_LOCK_EN
  modport master (
    output req, in, out_ready, lock,
    input  sel, grant, out_valid, out, busy
  );
  modport slave (
    input  req, in, out_ready, lock,
    output sel, grant, out_valid, out, busy
  );
`else
  modport master (
    output req, in, out_ready,
    input  sel, grant, out_valid, out, busy
  );
  modport slave (
    input  req, in, out_ready,
    output sel, grant, out_valid, out, busy
  );
`endif
endinterface

// File: rtl/mux8x1_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 lane mux among 8 requesters, bursts of up to
// BURST_MAX beats per grant. Optional grant hold via lock when MUX_RR_LOCK_EN is defined.
module mux8x1_rr_scheduler #(
  parameter int DATA_W    = 1,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux8x1_rr_scheduler_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_t     state_r, state_s;
  logic [2:0] sel_r, sel_s;
  logic [7:0] grant_r, grant_s;
  logic [3:0] beat_cnt_r, beat_cnt_s;
  logic [2:0] ptr_r, ptr_s;
  logic       lock_s;
  logic       out_valid_s;
  logic       accept_s;
  logic [2:0] pick_s;

  // First requesting lane at or after the pointer, scanning upward with 3-bit wrap.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

`ifdef MUX_RR_LOCK_EN
  assign lock_s = bus.lock;
`else
  assign lock_s = 1'b0;
`endif

  assign out_valid_s = (state_r == XFER);
  assign accept_s    = out_valid_s & bus.out_ready;
  assign pick_s      = rr_pick(bus.req, ptr_r);

  // Next-state logic: arbitration in IDLE, beat counting and release in XFER.
  always_comb begin
    state_s    = state_r;
    sel_s      = sel_r;
    grant_s    = grant_r;
    beat_cnt_s = beat_cnt_r;
    ptr_s      = ptr_r;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          sel_s      = pick_s;
          grant_s    = 8'd1 << pick_s;
          beat_cnt_s = 4'd0;
          state_s    = XFER;
        end else begin
          state_s    = IDLE;
        end
      end
      XFER: begin
        // A dropped request releases without counting a beat, even if accepted.
        if (!bus.req[sel_r]) begin
          state_s    = IDLE;
          grant_s    = 8'd0;
          beat_cnt_s = 4'd0;
          ptr_s      = sel_r + 3'd1;
        end else if (accept_s) begin
          if (!lock_s && (beat_cnt_r >= BURST_LIM - 4'd1)) begin
            state_s    = IDLE;
            grant_s    = 8'd0;
            beat_cnt_s = 4'd0;
            ptr_s      = sel_r + 3'd1;
          end else if (beat_cnt_r >= BURST_LIM) begin
            beat_cnt_s = BURST_LIM;
          end else begin
            beat_cnt_s = beat_cnt_r + 4'd1;
          end
        end else begin
          state_s = XFER;
        end
      end
      default: begin
        state_s    = IDLE;
        grant_s    = 8'd0;
        beat_cnt_s = 4'd0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sel_r      <= 3'd0;
      grant_r    <= 8'd0;
      beat_cnt_r <= 4'd0;
      ptr_r      <= 3'd0;
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      grant_r    <= grant_s;
      beat_cnt_r <= beat_cnt_s;
      ptr_r      <= ptr_s;
    end
  end

  // Lane data passes through unregistered; forced to zero outside a transfer.
  always_comb begin
    bus.out = '0;
    if (out_valid_s) begin
      bus.out = bus.in[sel_r*DATA_W +: DATA_W];
    end else begin
      bus.out = '0;
    end
  end

  assign bus.sel       = sel_r;
  assign bus.grant     = grant_r;
  assign bus.out_valid = out_valid_s;
  assign bus.busy      = out_valid_s;

endmodule

// File: tb/tb_mux8x1_rr_scheduler.sv
// Directed bench for mux8x1_rr_scheduler: dut_a uses BURST_MAX=1, dut_b BURST_MAX=4.
// Expectations are queued as stimulus is driven and checked one cycle later.
module tb_mux8x1_rr_scheduler;

  typedef struct {
    int         which;
    string      tag;
    logic       chk_sel;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic       out;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  exp_t sb[$];
  logic [7:0] in_a_v;
  logic [7:0] in_b_v;

  mux8x1_rr_scheduler_if #(.DATA_W(1)) ifa ();
  mux8x1_rr_scheduler_if #(.DATA_W(1)) ifb ();

  mux8x1_rr_scheduler #(.DATA_W(1), .BURST_MAX(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  mux8x1_rr_scheduler #(.DATA_W(1), .BURST_MAX(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int which, input string tag, input logic chk_sel,
                      input logic [2:0] sel, input logic [7:0] grant,
                      input logic valid, input logic out, input logic busy);
    exp_t e;
    e.which = which; e.tag = tag; e.chk_sel = chk_sel; e.sel = sel;
    e.grant = grant; e.valid = valid; e.out = out; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic exp_rst(input int which, input string tag);
    push(which, tag, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_idle(input int which, input string tag);
    push(which, tag, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_xfer(input int which, input string tag, input int lane);
    logic [7:0] lanes;
    lanes = (which == 0) ? in_a_v : in_b_v;
    push(which, tag, 1'b1, 3'(lane), 8'd1 << lane, 1'b1, lanes[lane], 1'b1);
  endtask

  task automatic tick();
    exp_t       e;
    logic [2:0] o_sel;
    logic [7:0] o_grant;
    logic       o_valid, o_out, o_busy;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e       = sb.pop_front();
      o_sel   = (e.which == 0) ? ifa.sel       : ifb.sel;
      o_grant = (e.which == 0) ? ifa.grant     : ifb.grant;
      o_valid = (e.which == 0) ? ifa.out_valid : ifb.out_valid;
      o_out   = (e.which == 0) ? ifa.out       : ifb.out;
      o_busy  = (e.which == 0) ? ifa.busy      : ifb.busy;
      if (e.chk_sel) begin
        compared++;
        assert (o_sel === e.sel) else begin
          mismatched++;
          $error("FAIL %s.sel dut%0d observed=%0d expected=%0d", e.tag, e.which, o_sel, e.sel);
        end
      end
      compared++;
      assert (o_grant === e.grant) else begin
        mismatched++;
        $error("FAIL %s.grant dut%0d observed=%02h expected=%02h", e.tag, e.which, o_grant, e.grant);
      end
      compared++;
      assert (o_valid === e.valid) else begin
        mismatched++;
        $error("FAIL %s.out_valid dut%0d observed=%b expected=%b", e.tag, e.which, o_valid, e.valid);
      end
      compared++;
      assert (o_out === e.out) else begin
        mismatched++;
        $error("FAIL %s.out dut%0d observed=%b expected=%b", e.tag, e.which, o_out, e.out);
      end
      compared++;
      assert (o_busy === e.busy) else begin
        mismatched++;
        $error("FAIL %s.busy dut%0d observed=%b expected=%b", e.tag, e.which, o_busy, e.busy);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    in_a_v     = 8'b1011_1010;
    in_b_v     = 8'b1011_1010;
    ifa.in     = in_a_v;
    ifb.in     = in_b_v;
    ifa.req    = 8'hFF;
    ifb.req    = 8'hFF;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
`ifdef MUX_RR_LOCK_EN
    ifa.lock = 1'b0;
    ifb.lock = 1'b0;
`endif
    rst_n = 1'b0;

    // Reset held two cycles with all lanes requesting
    repeat (2) begin
      exp_rst(0, "reset_a");
      exp_rst(1, "reset_b");
      tick();
    end

    // Round-robin wrap on dut_a: 0..7,0 with one bubble between grants
    rst_n   = 1'b1;
    ifb.req = 8'h00;
    for (int k = 0; k < 9; k++) begin
      exp_xfer(0, "rr_grant", k % 8);
      tick();
      if (k < 8) begin
        exp_idle(0, "rr_bubble");
        tick();
      end
    end
    ifa.req = 8'h00;
    exp_idle(0, "rr_drop");
    exp_idle(1, "b_quiet");
    tick();

    // Burst cap on dut_b: 4 beats of lane 2, bubble, regrant
    ifb.req = 8'h04;
    repeat (4) begin
      exp_xfer(1, "cap_beat", 2);
      tick();
    end
    exp_idle(1, "cap_bubble");
    tick();
    exp_xfer(1, "cap_regrant", 2);
    tick();
    ifb.req = 8'h00;
    exp_idle(1, "cap_drop");
    tick();

    // Stall then drop of lane 5; next scan starts at lane 6, not 4
    ifb.req       = 8'h20;
    ifb.out_ready = 1'b0;
    exp_xfer(1, "stall_grant", 5);
    tick();
    repeat (3) begin
      exp_xfer(1, "stall_hold", 5);
      tick();
    end
    ifb.req       = 8'h50;
    ifb.out_ready = 1'b1;
    exp_idle(1, "stall_drop");
    tick();
    exp_xfer(1, "stall_next", 6);
    tick();
    ifb.req = 8'h00;
    exp_idle(1, "stall_end");
    tick();

    // Move ptr to 1, then reset mid-burst of lane 3 and check ptr cleared
    ifb.req = 8'h01;
    exp_xfer(1, "pre_grant0", 0);
    tick();
    ifb.req = 8'h00;
    exp_idle(1, "pre_release");
    tick();
    ifb.req = 8'h08;
    repeat (3) begin
      exp_xfer(1, "mid_burst", 3);
      tick();
    end
    rst_n = 1'b0;
    exp_rst(0, "midrst_a");
    exp_rst(1, "midrst_b");
    tick();
    rst_n   = 1'b1;
    ifb.req = 8'h09;
    exp_xfer(1, "rst_ptr", 0);
    tick();
    ifb.req = 8'h00;
    exp_idle(1, "rst_ptr_drop");
    tick();

`ifdef MUX_RR_LOCK_EN
    // Lock holds lane 7 beyond the cap; release on first beat after unlock
    ifb.lock = 1'b1;
    ifb.req  = 8'h81;
    exp_xfer(1, "lock_grant", 7);
    tick();
    repeat (10) begin
      exp_xfer(1, "lock_hold", 7);
      tick();
    end
    ifb.lock = 1'b0;
    exp_idle(1, "lock_release");
    tick();
    exp_xfer(1, "lock_next", 0);
    tick();
    ifb.req = 8'h00;
    exp_idle(1, "lock_end");
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
